sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_pkg.sv | 10 +
 rtl/sipo_deserializer_if.sv | 27 ++
 rtl/sipo_shift_core.sv | 52 +++++
 rtl/sipo_deserializer.sv | 68 ++++++
 tb/tb_sipo_deserializer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared defaults and output-state encoding for the SIPO deserializer
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // The output holding register is either EMPTY or FULL.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial input / parallel output bundle of the SIPO deserializer
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                     din;
  logic                     en;
  logic                     clear;
  logic                     out_ready;
  logic [WIDTH-1:0]         dout;
  logic                     dout_valid;
  logic [$clog2(WIDTH)-1:0] bit_count;
  logic                     overrun;

  modport master (
    output din, en, clear, out_ready,
    input  dout, dout_valid, bit_count, overrun
  );

  modport slave (
    input  din, en, clear, out_ready,
    output dout, dout_valid, bit_count, overrun
  );

endinterface

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - MSB-first shift register and bit counter
// word_done_o is combinational: it marks the edge that consumes the last bit of a word.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic                     din_i,
  output logic [WIDTH-1:0]         word_o,
  output logic                     word_done_o,
  output logic [$clog2(WIDTH)-1:0] bit_count_o
);

  localparam int CW = $clog2(WIDTH);

  // Only WIDTH-1 bits are kept; the oldest bit of a word is never needed after the word forms.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;

  assign last_bit    = (cnt_q == CW'(WIDTH - 1));
  assign word_o      = {shift_q, din_i};
  assign word_done_o = en_i & ~clear_i & last_bit;
  assign bit_count_o = cnt_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (en_i) begin
      shift_d = (WIDTH-1)'({shift_q, din_i});
      cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - SIPO deserializer top: output holding register, EMPTY/FULL state, overrun
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  sipo_deserializer_if.slave  bus
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovr_q, ovr_d;
  logic             accept;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (bus.clear),
    .en_i        (bus.en),
    .din_i       (bus.din),
    .word_o      (word),
    .word_done_o (word_done),
    .bit_count_o (bus.bit_count)
  );

  assign accept = (state_q == ST_FULL) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    ovr_d   = ovr_q;
    if (word_done) begin
      // A word fits only if the holder is empty or being emptied on this same edge.
      if (state_q == ST_EMPTY || accept) begin
        dout_d  = word;
        state_d = ST_FULL;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      state_d = ST_EMPTY;
    end
    if (bus.clear) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state_q == ST_FULL);
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed and randomized bench for sipo_deserializer against a word-level model
module tb_sipo_deserializer;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sipo_deserializer_if #(.WIDTH(W)) bus ();

  sipo_deserializer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: partial word as an integer plus a bit tally, holder as value + valid flag.
  int pcnt = 0;
  int pval = 0;
  bit mv   = 1'b0;
  int md   = 0;
  bit mo   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit c, input bit e, input bit d, input bit rdy);
    bit acc;
    bit done;
    int wrd;
    done = 1'b0;
    wrd  = 0;
    if (r) begin
      pcnt = 0; pval = 0; mv = 1'b0; md = 0; mo = 1'b0;
    end else begin
      acc = mv && rdy;
      if (c) begin
        pcnt = 0; pval = 0; mo = 1'b0;
      end else if (e) begin
        pval = (pval * 2 + int'(d)) % (1 << W);
        pcnt = pcnt + 1;
        if (pcnt == W) begin
          done = 1'b1;
          wrd  = pval;
          pcnt = 0;
          pval = 0;
        end
      end
      if (done) begin
        if (!mv || acc) begin
          md = wrd;
          mv = 1'b1;
        end else begin
          mo = 1'b1;
        end
      end else if (acc) begin
        mv = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("dout",       64'(bus.dout),       64'(md));
    chk("dout_valid", 64'(bus.dout_valid), 64'(mv));
    chk("bit_count",  64'(bus.bit_count),  64'(pcnt));
    chk("overrun",    64'(bus.overrun),    64'(mo));
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit d, input bit rdy);
    reset         = r;
    bus.clear     = c;
    bus.en        = e;
    bus.din       = d;
    bus.out_ready = rdy;
    @(posedge clock);
    #1;
    model_update(r, c, e, d, rdy);
    compare_all();
  endtask

  task automatic send_word(input logic [7:0] w, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b1, w[i], (i == 0) ? rdy_last : 1'b0);
    end
  endtask

  initial begin
    logic [7:0] v;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_dout",       64'(bus.dout),       64'h0);
    chk("rst_dout_valid", 64'(bus.dout_valid), 64'h0);
    chk("rst_bit_count",  64'(bus.bit_count),  64'h0);
    chk("rst_overrun",    64'(bus.overrun),    64'h0);

    // A5 from bits 1,0,1,0,0,1,0,1
    send_word(8'hA5, 1'b0);
    chk("a5_dout",      64'(bus.dout),       64'hA5);
    chk("a5_valid",     64'(bus.dout_valid), 64'h1);
    chk("a5_bit_count", 64'(bus.bit_count),  64'h0);

    // FF while A5 still held -> dropped
    send_word(8'hFF, 1'b0);
    chk("ovr_dout",    64'(bus.dout),    64'hA5);
    chk("ovr_overrun", 64'(bus.overrun), 64'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_overrun", 64'(bus.overrun),    64'h0);
    chk("clr_valid",   64'(bus.dout_valid), 64'h1);

    // accept on the same edge as the last bit of 5A
    send_word(8'h5A, 1'b1);
    chk("same_edge_dout",    64'(bus.dout),       64'h5A);
    chk("same_edge_valid",   64'(bus.dout_valid), 64'h1);
    chk("same_edge_overrun", 64'(bus.overrun),    64'h0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("accept_valid", 64'(bus.dout_valid), 64'h0);

    // 3C with en toggling; en=0 cycles carry noise on din
    v = 8'h3C;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b1, v[i], 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (i == 4) chk("toggle_bit_count", 64'(bus.bit_count), 64'h4);
    end
    chk("toggle_dout",      64'(bus.dout),       64'h3C);
    chk("toggle_valid",     64'(bus.dout_valid), 64'h1);
    chk("toggle_bit_count", 64'(bus.bit_count),  64'h0);

    // partial word aborted by clear (en=1 ignored, accept honoured)
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("partial_bit_count", 64'(bus.bit_count), 64'h4);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_bit_count", 64'(bus.bit_count),  64'h0);
    chk("abort_valid",     64'(bus.dout_valid), 64'h0);
    send_word(8'h81, 1'b0);
    chk("after_abort_dout", 64'(bus.dout), 64'h81);

    // reset mid-frame with a word held; nothing may change before the edge
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    chk("sync_dout",      64'(bus.dout),       64'h81);
    chk("sync_valid",     64'(bus.dout_valid), 64'h1);
    chk("sync_bit_count", 64'(bus.bit_count),  64'h5);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("midrst_dout",      64'(bus.dout),       64'h0);
    chk("midrst_valid",     64'(bus.dout_valid), 64'h0);
    chk("midrst_bit_count", 64'(bus.bit_count),  64'h0);
    chk("midrst_overrun",   64'(bus.overrun),    64'h0);

    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 47) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
